// File: rtl/cim_xbar_tile.sv
// cim_xbar_tile: binary-cell crossbar tile with row-serial MVM, ADC delay and saturating per-column result read port.
module cim_xbar_tile #(
   parameter int xbar_size     = 256,
   parameter int datatype_size = 2,
   parameter int ADC_LATENCY   = 4,
   parameter int OUT_SHIFT     = 0,
   parameter int ACC_W         = datatype_size + $clog2(xbar_size) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_wgt_we,
   input  logic [$clog2(xbar_size)-1:0]  i_wgt_row,
   input  logic [$clog2(xbar_size)-1:0]  i_wgt_col,
   input  logic                          i_wgt_bit,
   input  logic                          i_wr_en,
   input  logic [$clog2(xbar_size)-1:0]  i_wr_addr,
   input  logic [datatype_size-1:0]      i_wr_data,
   input  logic                          i_start,
   output logic                          o_busy,
   output logic                          o_done,
   input  logic [$clog2(xbar_size)-1:0]  i_rd_addr,
   output logic [datatype_size-1:0]      o_data
);
   localparam int AW = $clog2(xbar_size);
   localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, ADC = 2'd2, UPDATE = 2'd3;
   localparam logic [AW-1:0] ROW_LAST = AW'(xbar_size - 1);
   localparam logic [AW-1:0] ADC_LAST = AW'(ADC_LATENCY > 0 ? ADC_LATENCY - 1 : 0);
   localparam logic [ACC_W-1:0] MAXV = ACC_W'((1 << datatype_size) - 1);

   logic [1:0]               state_q, state_d;
   logic [AW-1:0]            row_q, row_d;
   logic [xbar_size-1:0]     w_q      [xbar_size];
   logic [datatype_size-1:0] in_buf_q [xbar_size];
   logic [ACC_W-1:0]         acc_q    [xbar_size];
   logic [datatype_size-1:0] res_q    [xbar_size];
   logic [datatype_size-1:0] data_q;
   logic                     idle;

   assign idle   = state_q == IDLE;
   assign o_busy = !idle;
   assign o_done = state_q == UPDATE;
   assign o_data = data_q;

   function automatic logic [datatype_size-1:0] sat(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] s;
      s = a >> OUT_SHIFT;
      return s > MAXV ? MAXV[datatype_size-1:0] : s[datatype_size-1:0];
   endfunction

   // row_q doubles as the ADC wait counter
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      case (state_q)
         IDLE: begin
            state_d = i_start ? MAC : IDLE;
            row_d   = '0;
         end
         MAC: begin
            row_d   = row_q == ROW_LAST ? '0 : row_q + 1'b1;
            state_d = row_q != ROW_LAST ? MAC : (ADC_LATENCY == 0 ? UPDATE : ADC);
         end
         ADC: begin
            row_d   = row_q + 1'b1;
            state_d = row_q == ADC_LAST ? UPDATE : ADC;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (idle && i_wgt_we) w_q[i_wgt_row][i_wgt_col] <= i_wgt_bit;
      if (idle && i_wr_en) in_buf_q[i_wr_addr] <= i_wr_data;
      for (int c = 0; c < xbar_size; c++) begin
         if (idle && i_start) acc_q[c] <= '0;
         else if (state_q == MAC && w_q[row_q][c]) acc_q[c] <= acc_q[c] + ACC_W'(in_buf_q[row_q]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         data_q  <= '0;
         for (int c = 0; c < xbar_size; c++) res_q[c] <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         data_q  <= res_q[i_rd_addr];
         if (state_q == UPDATE)
            for (int c = 0; c < xbar_size; c++) res_q[c] <= sat(acc_q[c]);
      end
   end
endmodule

// File: tb/tb_cim_xbar_tile.sv
// tb_cim_xbar_tile: randomized scoreboard bench comparing two tile instances (shift 0 and 8) against a column-sum model.
module tb_cim_xbar_tile;
   localparam int N = 256, D = 2, AL = 4, RUN_LEN = N + AL + 1;

   logic clk = 0, rst = 1;
   logic i_wgt_we = 0, i_wgt_bit = 0, i_wr_en = 0, i_start = 0, rd_req = 0;
   logic [7:0] i_wgt_row = 0, i_wgt_col = 0, i_wr_addr = 0, i_rd_addr = 0;
   logic [D-1:0] i_wr_data = 0, data0, data8;
   logic busy0, done0, busy8, done8;

   always #5 clk = ~clk;

   cim_xbar_tile #(.xbar_size(N), .datatype_size(D), .ADC_LATENCY(AL), .OUT_SHIFT(0)) dut (
      .clk(clk), .rst(rst), .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_col(i_wgt_col),
      .i_wgt_bit(i_wgt_bit), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_start(i_start), .o_busy(busy0), .o_done(done0), .i_rd_addr(i_rd_addr), .o_data(data0));

   cim_xbar_tile #(.xbar_size(N), .datatype_size(D), .ADC_LATENCY(AL), .OUT_SHIFT(8)) dut8 (
      .clk(clk), .rst(rst), .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_col(i_wgt_col),
      .i_wgt_bit(i_wgt_bit), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_start(i_start), .o_busy(busy8), .o_done(done8), .i_rd_addr(i_rd_addr), .o_data(data8));

   typedef struct {int a; int e0; int e8;} exp_t;
   exp_t sbq[$];
   int vectors = 0, miscompares = 0;
   bit wm [N][N];
   int inm [N];
   int res0 [N], res8 [N];
   int known_cols[$];

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int satv(int v);
      return v > 3 ? 3 : v;
   endfunction

   function automatic int pick();
      return known_cols[$urandom_range(0, known_cols.size() - 1)];
   endfunction

   task automatic push_rd(int a);
      exp_t e;
      e.a = a; e.e0 = res0[a]; e.e8 = res8[a];
      sbq.push_back(e);
      i_rd_addr = 8'(a);
      rd_req = 1;
   endtask

   task automatic rd(int a);
      @(negedge clk);
      push_rd(a);
      @(negedge clk);
      rd_req = 0;
   endtask

   initial forever begin
      @(posedge clk);
      if (rd_req) begin
         @(negedge clk);
         if (sbq.size() == 0) check("sb_underflow", 1, 0);
         else begin
            exp_t e;
            e = sbq.pop_front();
            check($sformatf("rd_shift0[%0d]", e.a), 32'(data0), e.e0);
            check($sformatf("rd_shift8[%0d]", e.a), 32'(data8), e.e8);
         end
      end
   end

   // kind: 0 all ones, 1 diagonal only, 2 sparse random
   task automatic write_col(int c, int kind);
      for (int r = 0; r < N; r++) begin
         bit b;
         @(negedge clk);
         b = kind == 0 ? 1'b1 : kind == 1 ? bit'(r == c) : bit'($urandom_range(0, 63) == 0);
         i_wgt_we = 1; i_wgt_row = 8'(r); i_wgt_col = 8'(c); i_wgt_bit = b;
         wm[r][c] = b;
      end
      @(negedge clk);
      i_wgt_we = 0;
      known_cols.push_back(c);
   endtask

   // kind: 0 all ones, 1 only entry 5 = 2
   task automatic write_all_in(int kind);
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         i_wr_en = 1; i_wr_addr = 8'(a);
         i_wr_data = kind == 0 ? 2'd1 : (a == 5 ? 2'd2 : 2'd0);
         inm[a] = int'(i_wr_data);
      end
      @(negedge clk);
      i_wr_en = 0;
   endtask

   task automatic write_in(int a, int v);
      @(negedge clk);
      i_wr_en = 1; i_wr_addr = 8'(a); i_wr_data = D'(v);
      inm[a] = v;
      @(negedge clk);
      i_wr_en = 0;
   endtask

   task automatic clear_model();
      for (int c = 0; c < N; c++) begin res0[c] = 0; res8[c] = 0; end
   endtask

   // mode: 0 plain, 1 restart+write while busy, 2 reset at MAC row 100
   task automatic run(int mode, bit wr_with_start);
      int p0 [N], p8 [N];
      int cnt, dones, sel;
      @(negedge clk);
      i_start = 1;
      if (wr_with_start) begin
         i_wr_en = 1; i_wr_addr = 8'd5; i_wr_data = 2'd1; inm[5] = 1;
      end
      foreach (known_cols[k]) begin
         int c, raw;
         c = known_cols[k];
         raw = 0;
         for (int r = 0; r < N; r++) raw += wm[r][c] ? inm[r] : 0;
         p0[c] = satv(raw);
         p8[c] = satv(raw >> 8);
      end
      @(negedge clk);
      i_start = 0; i_wr_en = 0;
      cnt = 0; dones = 0; sel = known_cols[0];
      while (busy0 === 1'b1 && cnt < 1000) begin
         rd_req = 0; i_start = 0; i_wr_en = 0;
         if (done0) begin
            dones++;
            push_rd(sel);
            foreach (known_cols[k]) begin
               res0[known_cols[k]] = p0[known_cols[k]];
               res8[known_cols[k]] = p8[known_cols[k]];
            end
         end
         if (mode == 1 && cnt == 10) begin
            i_start = 1; i_wr_en = 1; i_wr_addr = 8'd5; i_wr_data = 2'd3;
         end
         if (cnt == 50) push_rd(pick());
         if (mode == 2 && cnt == 100) begin
            rst = 1;
            #1;
            check("rst_mid_busy", 32'(busy0), 0);
            check("rst_mid_done", 32'(done0), 0);
            check("rst_mid_data", 32'(data0), 0);
            clear_model();
            @(negedge clk);
            rst = 0;
            break;
         end
         cnt++;
         @(negedge clk);
      end
      i_start = 0; i_wr_en = 0;
      if (mode == 2) begin
         check("rst_run_cycles", cnt, 100);
         check("rst_run_dones", dones, 0);
      end else begin
         push_rd(sel);
         @(negedge clk);
         rd_req = 0;
         check("busy_cycles", cnt, RUN_LEN);
         check("done_pulses", dones, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

   initial begin
      clear_model();
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy0), 0);
      check("reset_done", 32'(done0), 0);
      check("reset_data", 32'(data0), 0);
      rst = 0;
      write_all_in(0);
      write_col(0, 0);
      write_col(5, 1);
      write_col(6, 1);
      for (int i = 0; i < 6; i++) write_col($urandom_range(7, N - 1), 2);
      rd(0);
      run(0, 0);
      rd(0); rd(5); rd(6);
      for (int i = 0; i < 4; i++) rd(pick());
      rd(0);
      @(negedge clk);
      rst = 1;
      #1;
      check("rst_idle_data", 32'(data0), 0);
      check("rst_idle_data8", 32'(data8), 0);
      check("rst_idle_busy", 32'(busy0), 0);
      clear_model();
      @(negedge clk);
      rst = 0;
      rd(0); rd(5);
      write_all_in(1);
      run(1, 0);
      rd(5); rd(6); rd(0);
      run(0, 0);
      rd(5);
      run(2, 0);
      rd(5); rd(0);
      run(0, 0);
      rd(5); rd(6);
      run(0, 1);
      rd(5); rd(0);
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < 32; i++) write_in($urandom_range(0, N - 1), $urandom_range(0, 3));
         run(0, 0);
         for (int i = 0; i < 6; i++) rd(pick());
      end
      repeat (5) @(negedge clk);
      check("sb_drain", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cim_xbar_tile.md
Name: cim_xbar_tile

Overview:
- Behavioural, synthesizable model of one CIM crossbar tile. It is the responder side of the fc_layer CIM interface.
- Accepts input-vector writes on o_cim_wr_addr/o_cim_data, runs a row-serial matrix-vector multiply on i_start, and asserts busy while computing.
- Serves quantized per-column results on a registered read port addressed by o_cim_rd_addr.
- Used in fc_layer-level benches and performance simulation, one instance per (v,h) tile.

Parameters:
- xbar_size, 256, crossbar rows = columns.
- datatype_size, 2, bits per input element and per output element.
- ADC_LATENCY, 4, extra busy cycles after accumulation (0 allowed).
- OUT_SHIFT, 0, right shift applied to the column sum before saturation.
- ACC_W, datatype_size+$clog2(xbar_size)+1, accumulator width per column.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- i_wgt_we  input  1  weight-cell write enable.
- i_wgt_row  input  $clog2(xbar_size)  weight row address.
- i_wgt_col  input  $clog2(xbar_size)  weight column address.
- i_wgt_bit  input  1  cell value (binary cell).
- i_wr_en  input  1  input-buffer write enable.
- i_wr_addr  input  $clog2(xbar_size)  input-buffer row address.
- i_wr_data  input  datatype_size  input element.
- i_start  input  1  start-MVM pulse.
- o_busy  output  1  computing.
- o_done  output  1  one-cycle pulse when results are updated.
- i_rd_addr  input  $clog2(xbar_size)  result column address.
- o_data  output  datatype_size  result at i_rd_addr.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: o_busy=0, o_done=0, o_data=0, state=IDLE, row counter=0, all result registers=0.
- Not reset: weight array and input buffer are memories and retain their contents.
- Storage:
  - w[xbar_size][xbar_size], 1 bit each.
  - in_buf[xbar_size], datatype_size bits each.
  - acc[xbar_size], ACC_W bits each.
  - res[xbar_size], datatype_size bits each.
- Writes:
  - i_wgt_we or i_wr_en write on the clock edge, only in IDLE.
  - Writes in any other state are dropped silently.
- FSM states: IDLE, MAC, ADC, UPDATE.
  - IDLE: on i_start, clear all acc, row=0, go to MAC; o_busy=1 from the next cycle.
  - MAC: each cycle, for every column c, acc[c] += w[row][c] ? in_buf[row] : 0. Increment row. After row xbar_size-1, go to ADC, or to UPDATE if ADC_LATENCY=0.
  - ADC: count ADC_LATENCY cycles, then go to UPDATE.
  - UPDATE: res[c] = min(acc[c]>>OUT_SHIFT, 2^datatype_size-1); o_done=1 for this cycle; go to IDLE.
  - o_busy is deasserted in the cycle after UPDATE.
- Busy duration: exactly xbar_size+ADC_LATENCY+1 cycles.
- Read port: o_data <= res[i_rd_addr] every cycle, 1-cycle latency, valid in all states.
  - During a computation, reads return the previous results (res is written only in UPDATE).
  - A read in the UPDATE cycle returns the old value; the new value is visible from the next cycle.
- Edge cases:
  - i_start while not IDLE: ignored.
  - i_start together with i_wr_en in IDLE: the write commits and is included in the MVM.
  - rst mid-operation: immediate return to IDLE, o_busy=0, res cleared; partial results are discarded.
  - Arithmetic is unsigned. ACC_W guarantees no accumulator overflow.

Test Plan:
1. Assert rst mid-simulation -> o_busy=0, o_done=0 and o_data=0 at once, without a clock edge. Read any address after release -> 0.
2. All weights=1, all inputs=1, OUT_SHIFT=0, pulse start -> o_busy high for 261 cycles, single o_done pulse; read col 0 -> 3 (256 saturated). Same with OUT_SHIFT=8 -> 1.
3. Diagonal weights, in_buf[5]=2, others 0 -> col 5 reads 2, col 6 reads 0, each one cycle after i_rd_addr is applied.
4. Second i_start at MAC row 10, plus i_wr_en to addr 5 with value 3 during busy -> run length is unchanged at 261. A rerun after done still gives col 5 = 2 (write dropped).
5. rst asserted at MAC row 100 -> o_busy=0 immediately, col 5 reads 0, no o_done. A new start then completes normally with col 5 = 2.
6. i_wr_en (addr 5, data 1) in the same cycle as i_start, with diagonal weights -> col 5 reads 1.
